// File: rtl/tt_um_contador.sv
// ============================================================================
// Module   : tt_um_contador
// Brief    : 8-bit up/down counter with load, clear, prescaler and saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_um_contador (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0] r_count;
  logic [2:0] r_presc;

  logic       w_en;
  logic       w_down;
  logic       w_load;
  logic       w_clear;
  logic       w_sat;
  logic [2:0] w_limit;
  logic       w_tick;
  logic [7:0] w_step;
  logic       w_unused;

  assign w_en    = ui_in[0];
  assign w_down  = ui_in[1];
  assign w_load  = ui_in[2];
  assign w_clear = ui_in[3];
  assign w_sat   = ui_in[6];

  // Terminal prescale value N-1 for N = 1, 2, 4, 8.
  always_comb begin
    w_limit = 3'd0;
    case (ui_in[5:4])
      2'd0:    w_limit = 3'd0;
      2'd1:    w_limit = 3'd1;
      2'd2:    w_limit = 3'd3;
      default: w_limit = 3'd7;
    endcase
  end

  // Exact match only: a prescaler left above a newly shrunk limit wraps mod 8.
  assign w_tick = (r_presc == w_limit);

  always_comb begin
    w_step = r_count;
    if (w_down) begin
      if (!(w_sat && (r_count == 8'h00))) begin
        w_step = r_count - 8'd1;
      end
    end else begin
      if (!(w_sat && (r_count == 8'hFF))) begin
        w_step = r_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'h00;
      r_presc <= 3'd0;
    end else if (w_clear) begin
      r_count <= 8'h00;
      r_presc <= 3'd0;
    end else if (w_load) begin
      r_count <= uio_in;
      r_presc <= 3'd0;
    end else if (w_en) begin
      if (w_tick) begin
        r_presc <= 3'd0;
        r_count <= w_step;
      end else begin
        r_presc <= r_presc + 3'd1;
      end
    end
  end

  assign uo_out  = r_count;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  assign w_unused = &{1'b0, ena, ui_in[7]};

endmodule

`default_nettype wire

// File: tb/tb_tt_um_contador.sv
// ============================================================================
// Module   : tb_tt_um_contador
// Brief    : Vector table, corner sequences and random stimulus vs a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_um_contador;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_vec;
  int n_err;
  int m_cnt;
  int m_pre;

  typedef struct {
    logic [7:0] ui;
    logic [7:0] uio;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  tt_um_contador dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: count and prescaler as plain integers, rules applied directly.
  task automatic model_edge(input logic [7:0] ui, input logic [7:0] uio);
    int n;
    if (ui[3]) begin
      m_cnt = 0;
      m_pre = 0;
    end else if (ui[2]) begin
      m_cnt = int'(uio);
      m_pre = 0;
    end else if (ui[0]) begin
      n = 1 << ui[5:4];
      if (m_pre == n - 1) begin
        m_pre = 0;
        if (!ui[1]) m_cnt = ui[6] ? ((m_cnt == 255) ? 255 : m_cnt + 1) : (m_cnt + 1) % 256;
        else        m_cnt = ui[6] ? ((m_cnt == 0) ? 0 : m_cnt - 1) : (m_cnt + 255) % 256;
      end else begin
        m_pre = (m_pre + 1) % 8;
      end
    end
  endtask

  task automatic apply(input logic [7:0] ui, input logic [7:0] uio, input string name);
    ui_in  = ui;
    uio_in = uio;
    @(posedge clk);
    model_edge(ui, uio);
    #1;
    chk(name, uo_out, 8'(m_cnt));
    chk("uio_oe", uio_oe, 8'h00);
    chk("uio_out", uio_out, 8'h00);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    m_cnt = 0;
    m_pre = 0;
    #1;
    chk("async_rst", uo_out, 8'h00);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic void add(input logic [7:0] ui, input logic [7:0] uio, input logic [7:0] exp);
    vec_t v;
    v.ui  = ui;
    v.uio = uio;
    v.exp = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [7:0] r_ui;
    int         r;
    n_vec  = 0;
    n_err  = 0;
    m_cnt  = 0;
    m_pre  = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    for (int i = 1; i <= 10; i++) add(8'h01, 8'h00, 8'(i));
    add(8'h04, 8'hFE, 8'hFE);
    add(8'h01, 8'h00, 8'hFF); add(8'h01, 8'h00, 8'h00); add(8'h01, 8'h00, 8'h01);
    add(8'h04, 8'hFE, 8'hFE);
    add(8'h41, 8'h00, 8'hFF); add(8'h41, 8'h00, 8'hFF); add(8'h41, 8'h00, 8'hFF);
    add(8'h04, 8'h01, 8'h01);
    add(8'h03, 8'h00, 8'h00); add(8'h03, 8'h00, 8'hFF); add(8'h03, 8'h00, 8'hFE);
    add(8'h04, 8'h01, 8'h01);
    add(8'h43, 8'h00, 8'h00); add(8'h43, 8'h00, 8'h00); add(8'h43, 8'h00, 8'h00);
    add(8'h0D, 8'h55, 8'h00);
    add(8'h04, 8'h55, 8'h55);
    add(8'h08, 8'h00, 8'h00);
    for (int i = 1; i <= 24; i++) add(8'h31, 8'h00, 8'(i / 8));

    #2;
    chk("reset_uo_out", uo_out, 8'h00);
    chk("reset_uio_oe", uio_oe, 8'h00);
    chk("reset_uio_out", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].ui, vecs[i].uio, "model");
      chk($sformatf("vec%0d", i), uo_out, vecs[i].exp);
    end

    // Mid-count asynchronous reset, then inputs ignored while held low.
    apply(8'h04, 8'h1F, "pre_rst_load");
    apply(8'h01, 8'h00, "pre_rst_step");
    chk("at_0x20", uo_out, 8'h20);
    rst_n = 1'b0;
    #1;
    chk("rst_immediate", uo_out, 8'h00);
    ui_in  = 8'h04;
    uio_in = 8'hAA;
    @(posedge clk);
    #1;
    chk("rst_hold", uo_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'h00);
    rst_n = 1'b1;
    m_cnt = 0;
    m_pre = 0;
    apply(8'h11, 8'h00, "post_rst_1");
    chk("post_rst_n2_a", uo_out, 8'h00);
    apply(8'h11, 8'h00, "post_rst_2");
    chk("post_rst_n2_b", uo_out, 8'h01);

    // Shrinking N with the prescaler already above the new limit.
    apply(8'h08, 8'h00, "clr");
    for (int i = 0; i < 5; i++) apply(8'h31, 8'h00, "n8_run");
    for (int i = 0; i < 4; i++) begin
      apply(8'h11, 8'h00, "n2_wrap");
      chk("presc_wrap_hold", uo_out, 8'h00);
    end
    apply(8'h11, 8'h00, "n2_tick");
    chk("presc_wrap_tick", uo_out, 8'h01);

    for (int i = 0; i < 600; i++) begin
      r      = int'($urandom_range(0, 99));
      r_ui   = 8'($urandom);
      r_ui[3] = (r < 3);
      r_ui[2] = (r >= 3 && r < 9);
      r_ui[0] = (r >= 25) ? 1'b1 : r_ui[0];
      ena    = 1'($urandom);
      apply(r_ui, 8'($urandom), "random");
      if (r == 99) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
